coef_update_writer: RTL and testbench
=====================================

// Module: coef_update_writer
// PURPOSE
//  Writer side of the FIR coefficient SP-SRAM interface. Accepts a 40-coefficient stream on a valid/ready port
//  and writes it into the four coefficient banks (10 taps each) through per-bank Csn/Wrn/Addr/Data.
//  Drives oUpdateFlag to the read FSM so coefficient reads and accumulation are suspended while banks are rewritten.
//  Sits between the host/coefficient source and the bank write MUX in front of SpSram.
// PARAMETERS
//  P_DATA_W         16   coefficient width (signed, two's complement)
//  P_TAPS_PER_BANK  10   words written per bank; bank addresses 0..P_TAPS_PER_BANK-1 (max 16)
// PORTS
//  iClk_12M        in   1         system clock, rising edge
//  iRst            in   1         reset, synchronous, active-high
//  iEnSample600k   in   1         1-cycle sample strobe (12 MHz domain); state handover points
//  iUpdateReq      in   1         level/pulse request to start a coefficient update session
//  iCoefValid      in   1         coefficient word valid
//  iCoefData       in   P_DATA_W  coefficient word, order bank1 tap0..9, bank2 .., bank4 tap9
//  oCoefReady      out  1         writer accepts word this cycle (transfer = iCoefValid & oCoefReady)
//  oUpdateFlag     out  1         1: update in progress (to read FSM iUpdateFlag)
//  oCsn_1..oCsn_4  out  1 each    bank chip select, active-low
//  oWrn_1..oWrn_4  out  1 each    bank write enable, active-low
//  oAddr           out  4         bank word address
//  oWrData         out  P_DATA_W  write data (shared by all banks)
//  oDone           out  1         1-cycle pulse: session complete, flag released
// BEHAVIOUR
//  Reset (iRst=1 at clock edge): state IDLE; oCoefReady=0, oUpdateFlag=0, all oCsn_*=1, all oWrn_*=1,
//   oAddr=0, oWrData=0, oDone=0, bank/tap counters=0. Reset mid-session aborts; partial bank contents remain.
//  States: IDLE -> ARM -> WRITE -> HOLD -> IDLE.
//   IDLE : iUpdateReq=1 -> ARM.
//   ARM  : wait for iEnSample600k=1; that cycle -> WRITE and oUpdateFlag<=1 (registered, so the flag is seen
//          by the reader at its next sample strobe). Counters cleared.
//   WRITE: oCoefReady=1 (combinational on state). On transfer: next cycle oCsn_b=0, oWrn_b=0 for bank b=bankCnt+1
//          only, oAddr=tapCnt, oWrData=iCoefData (1-cycle latency, one write per cycle, back-to-back allowed).
//          No transfer -> all Csn/Wrn=1 next cycle (stall); address/data hold last value.
//          tapCnt wraps P_TAPS_PER_BANK-1 -> 0 with bankCnt+1. Transfer of bank4 tap P_TAPS_PER_BANK-1 -> HOLD;
//          oCoefReady=0 from the following cycle.
//   HOLD : last write strobe issued on first HOLD cycle; oUpdateFlag stays 1 until next iEnSample600k=1,
//          then oUpdateFlag<=0, oDone<=1 for one cycle, -> IDLE.
//  iUpdateReq in ARM/WRITE/HOLD ignored (no restart). iUpdateReq in the oDone cycle starts a new session.
//  iEnSample600k coincident with a WRITE transfer: no effect on WRITE. Strobe arriving in the same cycle as entry
//   to HOLD is not used; HOLD waits for the next strobe.
//  Never more than one oCsn_* low in any cycle; oCsn_*=0 only with oWrn_*=0 (writer never reads).
//  Words per session fixed at 4*P_TAPS_PER_BANK; extra valid words after completion are not accepted.
// CONFIGURATION
//  COEF_CHECKSUM_EN defined: adds output oChecksum [P_DATA_W+5:0], signed sum of all accepted words in the
//   session, sign-extended, cleared on ARM->WRITE, reset 0, final value stable from the oDone cycle until next
//   session start. Undefined: port and adder absent; all other behaviour identical.
// TESTING
//  T1 reset: iRst=1 for 2 cycles mid-WRITE -> next cycle all Csn/Wrn=1, oUpdateFlag=0, oCoefReady=0, state IDLE.
//  T2 full load: req, strobe, 40 back-to-back words 0x0001..0x0028 -> bank1 addr0..9 = 1..10, bank4 addr9 = 0x28;
//     oDone 1 cycle after first strobe following the last write; checksum (if EN) = 820.
//  T3 stalls: drop iCoefValid every 3rd cycle -> no strobe in stall cycles, same final memory image as T2.
//  T4 flag timing: oUpdateFlag rises cycle after 1st strobe post-req, falls cycle after 1st strobe in HOLD.
//  T5 bank wrap: words 10/11 -> oCsn_1 low at addr9 then oCsn_2 low at addr0 on consecutive cycles.
//  T6 negative data: load all 0x8000 -> oWrData=0x8000 each write; checksum (if EN) = -1310720.

Source files
------------

// File: rtl/coef_update_writer.sv
// Coefficient writer: streams 4 x P_TAPS_PER_BANK words into the coefficient SP-SRAM banks; optional COEF_CHECKSUM_EN.
// Latency: one cycle from accepted word to bank write strobe; flag changes one cycle after a sample strobe.
// Backpressure: oCoefReady is high only while writing, so the source stalls outside WRITE and after the last word.
module coef_update_writer #(
    parameter int P_DATA_W        = 16,
    parameter int P_TAPS_PER_BANK = 10
) (
    input  logic                       iClk_12M,
    input  logic                       iRst,
    input  logic                       iEnSample600k,
    input  logic                       iUpdateReq,
    input  logic                       iCoefValid,
    input  logic [P_DATA_W-1:0]        iCoefData,
    output logic                       oCoefReady,
    output logic                       oUpdateFlag,
    output logic                       oCsn_1,
    output logic                       oCsn_2,
    output logic                       oCsn_3,
    output logic                       oCsn_4,
    output logic                       oWrn_1,
    output logic                       oWrn_2,
    output logic                       oWrn_3,
    output logic                       oWrn_4,
    output logic [3:0]                 oAddr,
    output logic [P_DATA_W-1:0]        oWrData,
`ifdef COEF_CHECKSUM_EN
    output logic signed [P_DATA_W+5:0] oChecksum,
`endif
    output logic                       oDone
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARM   = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [3:0] LP_LAST_TAP = 4'(P_TAPS_PER_BANK - 1);

    logic [1:0]          r_state;
    logic [1:0]          r_bank_cnt;
    logic [3:0]          r_tap_cnt;
    logic                r_flag;
    logic                r_done;
    logic [3:0]          r_csn;
    logic [3:0]          r_wrn;
    logic [3:0]          r_addr;
    logic [P_DATA_W-1:0] r_wrdata;

    logic w_ready;
    logic w_xfer;
    logic w_arm_go;

    assign w_ready  = (r_state == S_WRITE);
    assign w_xfer   = w_ready & iCoefValid;
    assign w_arm_go = (r_state == S_ARM) & iEnSample600k;

    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            r_state    <= S_IDLE;
            r_bank_cnt <= 2'd0;
            r_tap_cnt  <= 4'd0;
            r_flag     <= 1'b0;
            r_done     <= 1'b0;
            r_csn      <= 4'hF;
            r_wrn      <= 4'hF;
            r_addr     <= 4'd0;
            r_wrdata   <= '0;
        end else begin
            // Strobes default inactive; only a transfer pulls one bank low for a cycle.
            r_done <= 1'b0;
            r_csn  <= 4'hF;
            r_wrn  <= 4'hF;
            case (r_state)
                S_IDLE: begin
                    if (iUpdateReq) begin
                        r_state <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (iEnSample600k) begin
                        r_state    <= S_WRITE;
                        r_flag     <= 1'b1;
                        r_bank_cnt <= 2'd0;
                        r_tap_cnt  <= 4'd0;
                    end
                end
                S_WRITE: begin
                    if (iCoefValid) begin
                        r_csn    <= ~(4'b0001 << r_bank_cnt);
                        r_wrn    <= ~(4'b0001 << r_bank_cnt);
                        r_addr   <= r_tap_cnt;
                        r_wrdata <= iCoefData;
                        if (r_tap_cnt == LP_LAST_TAP) begin
                            r_tap_cnt <= 4'd0;
                            if (r_bank_cnt == 2'd3) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_bank_cnt <= r_bank_cnt + 2'd1;
                            end
                        end else begin
                            r_tap_cnt <= r_tap_cnt + 4'd1;
                        end
                    end
                end
                S_HOLD: begin
                    // The flag is held until the reader's next sample point so it never sees a half-written set.
                    if (iEnSample600k) begin
                        r_state <= S_IDLE;
                        r_flag  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef COEF_CHECKSUM_EN
    logic signed [P_DATA_W+5:0] r_checksum;

    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            r_checksum <= '0;
        end else if (w_arm_go) begin
            r_checksum <= '0;
        end else if (w_xfer) begin
            r_checksum <= r_checksum + {{6{iCoefData[P_DATA_W-1]}}, iCoefData};
        end
    end

    assign oChecksum = r_checksum;
`endif

    assign oCoefReady  = w_ready;
    assign oUpdateFlag = r_flag;
    assign oDone       = r_done;
    assign oAddr       = r_addr;
    assign oWrData     = r_wrdata;
    assign oCsn_1      = r_csn[0];
    assign oCsn_2      = r_csn[1];
    assign oCsn_3      = r_csn[2];
    assign oCsn_4      = r_csn[3];
    assign oWrn_1      = r_wrn[0];
    assign oWrn_2      = r_wrn[1];
    assign oWrn_3      = r_wrn[2];
    assign oWrn_4      = r_wrn[3];

endmodule

// File: tb/tb_coef_update_writer.sv
// Testbench for coef_update_writer: randomized sessions against a word-indexed session model and a bank memory image.
module tb_coef_update_writer;

    localparam int DW = 16;
    localparam int T  = 10;
    localparam int N  = 4 * T;

    logic          clk = 1'b0;
    logic          rst, req, stb, vld;
    logic [DW-1:0] dat;
    logic          ready, flag, done;
    logic          csn1, csn2, csn3, csn4, wrn1, wrn2, wrn3, wrn4;
    logic [3:0]    addr;
    logic [DW-1:0] wdat;
`ifdef COEF_CHECKSUM_EN
    logic signed [DW+5:0] cks;
`endif

    always #5 clk = ~clk;

    coef_update_writer #(.P_DATA_W(DW), .P_TAPS_PER_BANK(T)) dut (
        .iClk_12M(clk), .iRst(rst), .iEnSample600k(stb), .iUpdateReq(req),
        .iCoefValid(vld), .iCoefData(dat), .oCoefReady(ready), .oUpdateFlag(flag),
        .oCsn_1(csn1), .oCsn_2(csn2), .oCsn_3(csn3), .oCsn_4(csn4),
        .oWrn_1(wrn1), .oWrn_2(wrn2), .oWrn_3(wrn3), .oWrn_4(wrn4),
        .oAddr(addr), .oWrData(wdat),
`ifdef COEF_CHECKSUM_EN
        .oChecksum(cks),
`endif
        .oDone(done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Session model: phase is implied by armed/active flags and how many words have been taken.
    bit            m_armed, m_active, e_done;
    int            m_words, m_sum, e_bank;
    logic [3:0]    e_addr;
    logic [DW-1:0] e_data;
    logic [DW-1:0] exp_img [4][16];
    logic [DW-1:0] obs_img [4][16];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit q, input bit s, input bit v, input logic [DW-1:0] d);
        logic [3:0] exp_strb, got_csn, got_wrn;
        int k;
        rst = r; req = q; stb = s; vld = v; dat = d;
        @(posedge clk);
        e_done = 0;
        e_bank = 0;
        if (r) begin
            m_armed = 0; m_active = 0; m_words = 0; m_sum = 0;
            e_addr = '0; e_data = '0;
        end else if (m_active && m_words < N) begin
            if (v) begin
                k = m_words;
                e_bank = k / T + 1;
                e_addr = 4'(k % T);
                e_data = d;
                exp_img[k / T][k % T] = d;
                m_sum += int'($signed(d));
                m_words++;
            end
        end else if (m_active) begin
            if (s) begin
                m_active = 0;
                e_done = 1;
            end
        end else if (m_armed) begin
            if (s) begin
                m_armed = 0; m_active = 1; m_words = 0; m_sum = 0;
            end
        end else if (q) begin
            m_armed = 1;
        end
        #1;
        cyc++;
        exp_strb = 4'hF;
        if (e_bank != 0) exp_strb[e_bank-1] = 1'b0;
        got_csn = {csn4, csn3, csn2, csn1};
        got_wrn = {wrn4, wrn3, wrn2, wrn1};
        chk("ready", 32'(ready), 32'(m_active && m_words < N));
        chk("flag", 32'(flag), 32'(m_active));
        chk("done", 32'(done), 32'(e_done));
        chk("csn", 32'(got_csn), 32'(exp_strb));
        chk("wrn", 32'(got_wrn), 32'(exp_strb));
        chk("addr", 32'(addr), 32'(e_addr));
        chk("wrdata", 32'(wdat), 32'(e_data));
`ifdef COEF_CHECKSUM_EN
        chk("checksum", 32'(int'(cks)), 32'(m_sum));
`endif
        for (int b = 0; b < 4; b++) begin
            if (!got_csn[b] && !got_wrn[b]) obs_img[b][addr] = wdat;
        end
    endtask

    // vmode: 0 back-to-back, 1 drop every 3rd cycle, 2 random; dmode: 0 ramp, 1 0x8000, 2 random; smode: 0 every 20 cycles, 1 random
    task automatic session(input int vmode, input int dmode, input int smode, input int exp_sum, input bit use_sum);
        int budget;
        bit s, v, q;
        logic [DW-1:0] d;
        step(0, 1, 0, 0, '0);
        budget = 800;
        while (!e_done && budget > 0) begin
            budget--;
            s = (smode == 0) ? (cyc % 20 == 0) : ($urandom_range(0, 6) == 0);
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 3 != 2) : 1'($urandom_range(0, 1));
            d = (dmode == 0) ? DW'(m_words + 1) : (dmode == 1) ? 16'h8000 : DW'($urandom);
            q = ($urandom_range(0, 3) == 0);
            step(0, q, s, v, d);
        end
        chk("session_timeout", 32'(e_done), 32'd1);
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < T; a++)
                chk($sformatf("img_b%0d_a%0d", b + 1, a), 32'(obs_img[b][a]), 32'(exp_img[b][a]));
`ifdef COEF_CHECKSUM_EN
        if (use_sum) chk("checksum_final", 32'(int'(cks)), 32'(exp_sum));
`endif
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 16'h1234);
    endtask

    initial begin
        m_armed = 0; m_active = 0; m_words = 0; m_sum = 0;
        e_bank = 0; e_addr = '0; e_data = '0; e_done = 0;
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 16; a++) begin
                exp_img[b][a] = '0;
                obs_img[b][a] = '0;
            end

        step(1, 0, 0, 0, '0);
        step(1, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 16'h5555);

        // Full ramp load, then the fixed image points it must produce
        session(0, 0, 0, 820, 1);
        for (int a = 0; a < T; a++) chk($sformatf("ramp_b1_a%0d", a), 32'(obs_img[0][a]), 32'(a + 1));
        chk("ramp_b4_a9", 32'(obs_img[3][9]), 32'h28);

        // Same load with periodic stalls
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 16; a++) obs_img[b][a] = '0;
        session(1, 0, 0, 820, 1);
        chk("stall_b2_a0", 32'(obs_img[1][0]), 32'd11);
        chk("stall_b4_a9", 32'(obs_img[3][9]), 32'h28);

        // Most-negative data throughout
        session(0, 1, 0, -1310720, 1);
        chk("neg_b3_a5", 32'(obs_img[2][5]), 32'h8000);

        // Reset in the middle of a WRITE session
        step(0, 1, 0, 0, '0);
        for (int i = 0; i < 200 && !(m_active && m_words >= 15); i++)
            step(0, 0, (cyc % 20 == 0), 1, DW'($urandom));
        chk("reached_mid_write", 32'(m_words >= 15), 32'd1);
        step(1, 0, 0, 1, 16'hAAAA);
        step(1, 0, 0, 1, 16'hAAAA);
        step(0, 0, 1, 1, 16'hAAAA);
        chk("post_rst_flag", 32'(flag), 32'd0);
        chk("post_rst_ready", 32'(ready), 32'd0);

        // Randomized sessions
        for (int n = 0; n < 6; n++) session(2, 2, n % 2, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
